bitrev_reorder_buf: RTL
=======================

# bitrev_reorder_buf

Frame reorder buffer for the FFT datapath. It accepts a frame of samples in natural order and streams the same frame out in bit-reversed address order. Bits [n:1] of the word index are reversed and bit 0 (the LSB) is kept, with n = 6..13 selected by a 3-bit mode code. It sits between the sample source and the radix-2 butterfly stage, so the butterfly memory can be filled without per-access address permutation.

## Interface
- `dat_w`, default 16: sample word width.
- `lg_max`, default 13: largest supported n. Buffer depth is 2^(lg_max+1) words.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: reset; synchronous, active-high.
- `bitrev_i`  in  3: mode code. n = 6 + bitrev_i; frame length L = 2^(n+1). If n > lg_max, then n = lg_max.
- `dat_i`  in  dat_w: input sample.
- `valid_i`  in  1: input sample present.
- `ready_o`  out  1: buffer accepts input.
- `dat_o`  out  dat_w: output sample.
- `valid_o`  out  1: dat_o valid.
- `ready_i`  in  1: downstream accepts output.
- `last_o`  out  1: high together with valid_o on the final word of a frame.
- `busy_o`  out  1: a frame is in progress (first input accepted, last output not yet consumed).

## Operation
- Handshakes: input transfer occurs when valid_i && ready_o. Output transfer occurs when valid_o && ready_i.
- States:
  - FILL: ready_o=1. Each transfer writes dat_i at address wcnt, then wcnt++. On the transfer with wcnt==0, n is latched from bitrev_i. bitrev_i is ignored for the rest of the frame. On the transfer with wcnt==L-1, go to DRAIN and clear rcnt.
  - DRAIN: ready_o=0. A read of address rev(rcnt) is issued when rcnt<L and (!valid_o || ready_i); each issued read increments rcnt. When the output transfer with last_o=1 completes, go to FILL and clear wcnt.
- Address permutation: rev(j)[0] = j[0]; rev(j)[i] = j[n+1-i] for 1≤i≤n; bits above n are 0. This is self-inverse.
- Memory: single-port behaviour, synchronous read. The read data register updates only on an issued read, so dat_o holds stable during stalls.
- valid_o is set the cycle after an issued read. It is cleared on an output transfer with no read issued in the same cycle.
- last_o = valid_o && (word presented was read at rcnt==L-1).
- Counters are n+2 bits wide, enough to hold the value L; no wrap-around within a frame.
- Only one frame is in flight; there is no overlap of fill and drain.
- Reset (any cycle, including mid-fill or mid-drain) gives: state FILL, wcnt=rcnt=0, the partial frame is discarded, and memory contents are left untouched.
- Reset values: ready_o=1, valid_o=0, last_o=0, busy_o=0, dat_o=0.

## Timing
- Write: a sample accepted in cycle t is readable from cycle t+1.
- Last input accepted in cycle t:
  - cycle t+1: state DRAIN, ready_o=0, first read issued.
  - cycle t+2: valid_o=1.
- With ready_i held high, output is one word per cycle. Frame of L words: first input to last output spans 2L+1 cycles.
- Stall: if ready_i=0 while valid_o=1, then dat_o, valid_o and last_o all hold and no read is issued.
- Last output transfer in cycle t: in cycle t+1 state is FILL, ready_o=1 and valid_o=0 (no bubble on input side beyond this).
- valid_i is ignored in DRAIN; there is no backpressure loss because ready_o=0.
- busy_o rises the cycle after the first input transfer and falls the cycle after the last output transfer.

## Test plan
- **Reset values:** assert rst_i for 2 cycles → ready_o=1, valid_o=0, last_o=0, busy_o=0.
- **n=6 order (bitrev_i=000, L=128):** input dat_i = index 0..127, ready_i=1. Outputs in order are 0, 1, 64, 65, 32, 33, 96, 97, …, 126, 127. last_o is high only on word 127. First valid_o appears 2 cycles after the final input.
- **n=13 with random stalls (bitrev_i=111, L=16384):** input = index, ready_i toggled randomly → out[j] = rev(j) (e.g. out[2]=8192, out[4]=4096). dat_o is stable whenever valid_o && !ready_i. There are no duplicate or dropped words.
- **Mode latching:** bitrev_i changes from 000 to 001 after the first accepted input → the frame still uses L=128. The next frame, started with bitrev_i=001, uses L=256; its out[2]=128.
- **Reset mid-drain:** apply rst_i after 10 outputs of a 128-word frame → next cycle valid_o=0 and ready_o=1. A new frame of values 1000+index produces outputs 1000, 1001, 1064, … with no stale words.
- **Clamp (lg_max=8, bitrev_i=111):** frame treated as n=8, L=512 → out[2]=256, and last_o is high on word 511.

Source files
------------

// File: rtl/bitrev_if.sv
// Stream interface of the bit-reversal reorder buffer: mode, input stream, output stream and status.
// The slave modport is the buffer side.
interface bitrev_if #(
  parameter int unsigned dat_w = 16
) ();
  logic [2:0]       bitrev_i;
  logic [dat_w-1:0] dat_i;
  logic             valid_i;
  logic             ready_o;
  logic [dat_w-1:0] dat_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;
  logic             busy_o;

  modport master (
    output bitrev_i, dat_i, valid_i, ready_i,
    input  ready_o, dat_o, valid_o, last_o, busy_o
  );

  modport slave (
    input  bitrev_i, dat_i, valid_i, ready_i,
    output ready_o, dat_o, valid_o, last_o, busy_o
  );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// Frame reorder buffer: fills a frame in natural order, then drains it in bit-reversed order
// of index bits [n:1] with bit 0 kept.
module bitrev_reorder_buf #(
  parameter int unsigned dat_w  = 16,
  parameter int unsigned lg_max = 13
) (
  input logic      clk_i,
  input logic      rst_i,
  bitrev_if.slave  bus
);
  localparam int unsigned AddrW = lg_max + 1;
  localparam int unsigned CntW  = lg_max + 2;

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  wcnt_q, wcnt_d;
  logic [CntW-1:0]  rcnt_q, rcnt_d;
  logic [4:0]       n_q, n_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic [dat_w-1:0] dat_q;
  logic [dat_w-1:0] mem_q [2**AddrW];

  logic [4:0]       req_sum, n_req, n_cur;
  logic [CntW-1:0]  len, last_idx;
  logic [lg_max-1:0] hi_rev, hi_sh;
  logic [AddrW-1:0] raddr, waddr;
  logic             wr_en, rd_en, out_xfer;

  assign req_sum  = {2'b00, bus.bitrev_i} + 5'd6;
  assign n_req    = (req_sum > 5'(lg_max)) ? 5'(lg_max) : req_sum;
  // The mode is taken from bitrev_i only on the first word of a frame.
  assign n_cur    = (state_q == StFill && wcnt_q == '0) ? n_req : n_q;
  assign len      = {{(CntW-1){1'b0}}, 1'b1} << (n_cur + 5'd1);
  assign last_idx = len - CntW'(1);

  // Reverse the full field [lg_max:1], then shift down so only bits [n:1] land in place.
  always_comb begin
    hi_rev = '0;
    for (int i = 0; i < int'(lg_max); i++) begin
      hi_rev[i] = rcnt_q[int'(lg_max) - i];
    end
  end
  assign hi_sh = hi_rev >> (5'(lg_max) - n_q);
  assign raddr = {hi_sh, rcnt_q[0]};
  assign waddr = wcnt_q[AddrW-1:0];

  assign out_xfer = valid_q && bus.ready_i;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    n_d     = n_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (bus.valid_i) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + CntW'(1);
          busy_d = 1'b1;
          if (wcnt_q == '0) n_d = n_req;
          if (wcnt_q == last_idx) begin
            state_d = StDrain;
            rcnt_d  = '0;
          end
        end
      end
      StDrain: begin
        if (rcnt_q < len && (!valid_q || bus.ready_i)) begin
          rd_en   = 1'b1;
          rcnt_d  = rcnt_q + CntW'(1);
          valid_d = 1'b1;
          last_d  = (rcnt_q == last_idx);
        end else if (out_xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if (out_xfer && last_q) begin
          state_d = StFill;
          wcnt_d  = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFill;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      n_q     <= 5'd6;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      if (rd_en) dat_q <= mem_q[raddr];
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[waddr] <= bus.dat_i;
  end

  assign bus.ready_o = (state_q == StFill);
  assign bus.valid_o = valid_q;
  assign bus.last_o  = valid_q && last_q;
  assign bus.busy_o  = busy_q;
  assign bus.dat_o   = dat_q;
endmodule
